// File: rtl/sram_bridge_2432_pkg.sv
// Shared definitions for the 2432 SRAM bridge: FSM states, lane geometry and
// the lane-selection helper used when walking the byte-enable mask.
package sram_bridge_2432_pkg;

    localparam int LANE_W = 8;
    localparam int LANE_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Lanes are always serviced in ascending order, so pick the lowest set bit.
    function automatic logic [1:0] lowest_lane(input logic [LANE_N-1:0] mask);
        logic [1:0] lane;
        lane = 2'd0;
        for (int i = LANE_N - 1; i >= 0; i--) begin
            if (mask[i]) lane = 2'(i);
        end
        return lane;
    endfunction

endpackage

// File: rtl/sram_bridge_2432_byte_cycle.sv
// One byte access to the asynchronous SRAM: a SETUP cycle followed by
// WAIT_STATES+1 STROBE cycles, with read capture on the final strobe edge.
module sram_byte_cycle
    import sram_bridge_2432_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic              i_clk,
    input  logic              i_rstb,
    input  logic              i_setup,
    input  logic              i_strobe,
    input  logic              i_write,
    input  logic [LANE_W-1:0] i_sram_din,
    output logic              o_done,
    output logic              o_cap_en,
    output logic [LANE_W-1:0] o_cap_byte,
    output logic              o_sram_ceb,
    output logic              o_sram_oeb,
    output logic              o_sram_web
);

    localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);

    logic [2:0] wait_cnt;

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            wait_cnt <= 3'd0;
        end else if (i_setup) begin
            wait_cnt <= 3'd0;
        end else if (i_strobe && !o_done) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

    assign o_done     = i_strobe && (wait_cnt == LAST_CNT);
    assign o_cap_en   = o_done && !i_write;
    assign o_cap_byte = i_sram_din;

    // Strobes decode straight from the phase so a reset drops them at once.
    assign o_sram_ceb = !(i_setup || i_strobe);
    assign o_sram_oeb = !(i_strobe && !i_write);
    assign o_sram_web = !(i_strobe && i_write);

endmodule

// File: rtl/sram_bridge_2432.sv
// CPU data-port responder: turns one byte-enabled word request into a run of
// byte accesses on an 8-bit asynchronous SRAM, stalling the CPU meanwhile.
module sram_bridge_2432
    import sram_bridge_2432_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_STATES = 1
) (
    input  logic              i_clk,
    input  logic              i_rstb,
    input  logic [23:0]       i_daddr,
    input  logic [31:0]       i_dout,
    input  logic              i_ram_rd,
    input  logic [3:0]        i_ram_wr,
    output logic [31:0]       o_din,
    output logic              o_cpu_clk_en,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [7:0]        o_sram_dout,
    input  logic [7:0]        i_sram_din,
    output logic              o_sram_ceb,
    output logic              o_sram_oeb,
    output logic              o_sram_web,
    output logic              o_busy
);

    state_t              state;
    state_t              state_nxt;
    logic                req;
    logic                wr_req;
    logic                is_write;
    logic [LANE_N-1:0]   mask;
    logic [ADDR_W-3:0]   word_addr;
    logic [31:0]         wdata;
    logic [31:0]         shadow;
    logic [31:0]         shadow_merged;
    logic [1:0]          lane;
    logic [LANE_N-1:0]   lane_bit;
    logic                more_lanes;
    logic                in_setup;
    logic                in_strobe;
    logic                byte_done;
    logic                cap_en;
    logic [LANE_W-1:0]   cap_byte;
    logic                unused_addr_lo;

    // A write wins over a simultaneous read; the read is simply dropped.
    assign wr_req     = |i_ram_wr;
    assign req        = i_ram_rd || wr_req;
    assign lane       = lowest_lane(mask);
    assign lane_bit   = 4'b0001 << lane;
    assign more_lanes = |(mask & ~lane_bit);

    assign o_sram_addr = {word_addr, lane};
    assign o_sram_dout = wdata[{lane, 3'b000} +: LANE_W];

    assign unused_addr_lo = ^i_daddr[1:0];
    if (ADDR_W < 24) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^i_daddr[23:ADDR_W];
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_STROBE;
            ST_STROBE: if (byte_done) state_nxt = more_lanes ? ST_SETUP : ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_cpu_clk_en = ((state == ST_IDLE) && !req) || (state == ST_DONE);
        o_busy       = (state != ST_IDLE);
        in_setup     = (state == ST_SETUP);
        in_strobe    = (state == ST_STROBE);
    end

    always_comb begin
        shadow_merged = shadow;
        shadow_merged[{lane, 3'b000} +: LANE_W] = cap_byte;
    end

    // The last byte lands on the same edge that enters DONE, so o_din takes the merged word.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            is_write  <= 1'b0;
            mask      <= '0;
            word_addr <= '0;
            wdata     <= '0;
            shadow    <= '0;
            o_din     <= '0;
        end else begin
            if ((state == ST_IDLE) && req) begin
                is_write  <= wr_req;
                mask      <= wr_req ? i_ram_wr : 4'b1111;
                word_addr <= i_daddr[ADDR_W-1:2];
                wdata     <= i_dout;
            end
            if (byte_done) begin
                mask <= mask & ~lane_bit;
            end
            if (cap_en) begin
                shadow <= shadow_merged;
                if (!more_lanes) o_din <= shadow_merged;
            end
        end
    end

    sram_byte_cycle #(
        .WAIT_STATES (WAIT_STATES)
    ) u_byte_cycle (
        .i_clk       (i_clk),
        .i_rstb      (i_rstb),
        .i_setup     (in_setup),
        .i_strobe    (in_strobe),
        .i_write     (is_write),
        .i_sram_din  (i_sram_din),
        .o_done      (byte_done),
        .o_cap_en    (cap_en),
        .o_cap_byte  (cap_byte),
        .o_sram_ceb  (o_sram_ceb),
        .o_sram_oeb  (o_sram_oeb),
        .o_sram_web  (o_sram_web)
    );

endmodule

// File: tb/tb_sram_bridge_2432.sv
// Bench for sram_bridge_2432: an SRAM pin model plus a transaction-level model
// of the expected byte accesses, stall length and returned read word.
module tb_sram_bridge_2432;

    localparam int ADDR_W = 20;
    localparam int WS     = 1;

    logic              i_clk = 1'b0;
    logic              i_rstb;
    logic [23:0]       i_daddr;
    logic [31:0]       i_dout;
    logic              i_ram_rd;
    logic [3:0]        i_ram_wr;
    logic [31:0]       o_din;
    logic              o_cpu_clk_en;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [7:0]        o_sram_dout;
    logic [7:0]        sram_din;
    logic              o_sram_ceb;
    logic              o_sram_oeb;
    logic              o_sram_web;
    logic              o_busy;

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  data;
        logic [7:0]  len;
    } acc_t;

    int          total = 0;
    int          bad = 0;
    acc_t        acc_q[$];
    acc_t        exp_q[$];
    logic        in_pulse = 1'b0;
    logic        mem_load = 1'b0;
    logic [7:0]  sram [0:(1<<ADDR_W)-1];
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] exp_din;
    int          exp_stall;
    int          stall;
    logic [31:0] din_seen;
    logic        timed_out;

    always #5 i_clk = ~i_clk;

    sram_bridge_2432 #(
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WS)
    ) dut (
        .i_clk        (i_clk),
        .i_rstb       (i_rstb),
        .i_daddr      (i_daddr),
        .i_dout       (i_dout),
        .i_ram_rd     (i_ram_rd),
        .i_ram_wr     (i_ram_wr),
        .o_din        (o_din),
        .o_cpu_clk_en (o_cpu_clk_en),
        .o_sram_addr  (o_sram_addr),
        .o_sram_dout  (o_sram_dout),
        .i_sram_din   (sram_din),
        .o_sram_ceb   (o_sram_ceb),
        .o_sram_oeb   (o_sram_oeb),
        .o_sram_web   (o_sram_web),
        .o_busy       (o_busy)
    );

    assign sram_din = (!o_sram_ceb && !o_sram_oeb) ? sram[o_sram_addr] : 8'hEE;

    always @(posedge i_clk) begin
        if (mem_load) begin
            for (int i = 0; i < 4096; i++) sram[i] <= ref_mem[i];
        end else if (!o_sram_ceb && !o_sram_web) begin
            sram[o_sram_addr] <= o_sram_dout;
        end
    end

    // Each contiguous oeb/web low run becomes one access record.
    always @(negedge i_clk) begin : monitor
        acc_t r;
        if (!o_sram_oeb || !o_sram_web) begin
            if (!in_pulse) begin
                r.wr   = !o_sram_web;
                r.addr = 24'(o_sram_addr);
                r.data = !o_sram_web ? o_sram_dout : 8'h00;
                r.len  = 8'd1;
                acc_q.push_back(r);
            end else if (acc_q.size() > 0) begin
                r = acc_q.pop_back();
                r.len = r.len + 8'd1;
                acc_q.push_back(r);
            end
            in_pulse <= 1'b1;
        end else begin
            in_pulse <= 1'b0;
        end
    end

    task automatic model_req(input logic rd, input logic [3:0] wr, input logic [23:0] a,
                             input logic [31:0] d);
        int base;
        int n;
        logic [3:0] lanes;
        exp_q.delete();
        base  = int'(a) % (1 << ADDR_W);
        base  = base - (base % 4);
        lanes = (wr != 4'd0) ? wr : (rd ? 4'hF : 4'h0);
        n     = 0;
        for (int l = 0; l < 4; l++) begin
            if (lanes[l]) begin
                acc_t e;
                e.wr   = (wr != 4'd0);
                e.addr = 24'(base + l);
                e.data = (wr != 4'd0) ? d[8*l +: 8] : 8'h00;
                e.len  = 8'(WS + 1);
                exp_q.push_back(e);
                n++;
                if (wr != 4'd0) ref_mem[(base + l) % 4096] = d[8*l +: 8];
            end
        end
        if (wr == 4'd0) begin
            exp_din = {ref_mem[(base + 3) % 4096], ref_mem[(base + 2) % 4096],
                       ref_mem[(base + 1) % 4096], ref_mem[base % 4096]};
        end
        exp_stall = 1 + n * (WS + 2);
    endtask

    task automatic cpu_access(input logic rd, input logic [3:0] wr, input logic [23:0] a,
                              input logic [31:0] d);
        @(negedge i_clk);
        acc_q.delete();
        i_ram_rd  = rd;
        i_ram_wr  = wr;
        i_daddr   = a;
        i_dout    = d;
        stall     = 0;
        timed_out = 1'b1;
        #1;
        for (int c = 0; c < 100; c++) begin
            if (o_cpu_clk_en) begin
                timed_out = 1'b0;
                break;
            end
            stall++;
            @(negedge i_clk);
        end
        din_seen = o_din;
    endtask

    task automatic idle_bus(input int n);
        @(negedge i_clk);
        i_ram_rd = 1'b0;
        i_ram_wr = 4'd0;
        i_daddr  = 24'd0;
        i_dout   = 32'd0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rstb = 1'b0;
        mem_load = 1'b1;
        repeat (2) @(negedge i_clk);
        mem_load = 1'b0;
        total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", o_busy); end
        total++; if ({o_sram_ceb, o_sram_oeb, o_sram_web} !== 3'b111) begin bad++; $display("[TB] FAIL reset_strobes got=%b want=111", {o_sram_ceb, o_sram_oeb, o_sram_web}); end
        total++; if (o_sram_addr !== '0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", o_sram_addr); end
        total++; if (o_sram_dout !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout got=%h want=00", o_sram_dout); end
        total++; if (o_din !== 32'h0) begin bad++; $display("[TB] FAIL reset_din got=%h want=0", o_din); end
        i_rstb = 1'b1;
        repeat (2) @(negedge i_clk);
        total++; if (o_cpu_clk_en !== 1'b1) begin bad++; $display("[TB] FAIL reset_clk_en got=%b want=1", o_cpu_clk_en); end
    endtask

    task automatic test_read();
        // Second read lands on the same word through address bits above ADDR_W.
        logic [23:0] addrs [2];
        addrs[0] = 24'h000104;
        addrs[1] = 24'hF00104;
        for (int t = 0; t < 2; t++) begin
            model_req(1'b1, 4'd0, addrs[t], 32'd0);
            cpu_access(1'b1, 4'd0, addrs[t], 32'd0);
            total++; if (timed_out || stall !== exp_stall) begin bad++; $display("[TB] FAIL read_stall got=%0d want=%0d", stall, exp_stall); end
            total++; if (din_seen !== exp_din) begin bad++; $display("[TB] FAIL read_din got=%h want=%h", din_seen, exp_din); end
            total++; if (acc_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL read_count got=%0d want=%0d", acc_q.size(), exp_q.size()); end
            else for (int i = 0; i < exp_q.size(); i++) begin
                total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL read_access%0d got=%h want=%h", i, acc_q[i], exp_q[i]); end
            end
            idle_bus(1);
        end
    endtask

    task automatic test_write();
        logic [3:0]  wr [2];
        logic [31:0] dat [2];
        logic [23:0] adr [2];
        logic [31:0] din_before;
        wr[0] = 4'b0100; dat[0] = 32'h00AB0000; adr[0] = 24'h000202;
        wr[1] = 4'b1010; dat[1] = 32'hDD00BB00; adr[1] = 24'h000300;
        for (int t = 0; t < 2; t++) begin
            din_before = exp_din;
            model_req(1'b0, wr[t], adr[t], dat[t]);
            cpu_access(1'b0, wr[t], adr[t], dat[t]);
            total++; if (timed_out || stall !== exp_stall) begin bad++; $display("[TB] FAIL write_stall got=%0d want=%0d", stall, exp_stall); end
            total++; if (din_seen !== din_before) begin bad++; $display("[TB] FAIL write_din_kept got=%h want=%h", din_seen, din_before); end
            total++; if (acc_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL write_count got=%0d want=%0d", acc_q.size(), exp_q.size()); end
            else for (int i = 0; i < exp_q.size(); i++) begin
                total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL write_access%0d got=%h want=%h", i, acc_q[i], exp_q[i]); end
            end
            idle_bus(1);
        end
    endtask

    task automatic test_priority();
        model_req(1'b1, 4'b1111, 24'h000400, 32'h76543210);
        cpu_access(1'b1, 4'b1111, 24'h000400, 32'h76543210);
        total++; if (timed_out || stall !== exp_stall) begin bad++; $display("[TB] FAIL prio_stall got=%0d want=%0d", stall, exp_stall); end
        total++; if (acc_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL prio_count got=%0d want=%0d", acc_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL prio_access%0d got=%h want=%h", i, acc_q[i], exp_q[i]); end
        end
        idle_bus(1);
    endtask

    task automatic test_back_to_back();
        model_req(1'b1, 4'd0, 24'h000400, 32'd0);
        cpu_access(1'b1, 4'd0, 24'h000400, 32'd0);
        total++; if (din_seen !== exp_din) begin bad++; $display("[TB] FAIL b2b_read_din got=%h want=%h", din_seen, exp_din); end
        total++; if (acc_q.size() !== 4) begin bad++; $display("[TB] FAIL b2b_read_count got=%0d want=4", acc_q.size()); end
        model_req(1'b0, 4'b0011, 24'h000404, 32'h0000C3C2);
        cpu_access(1'b0, 4'b0011, 24'h000404, 32'h0000C3C2);
        total++; if (timed_out || stall !== exp_stall) begin bad++; $display("[TB] FAIL b2b_stall got=%0d want=%0d", stall, exp_stall); end
        total++; if (din_seen !== exp_din) begin bad++; $display("[TB] FAIL b2b_din_kept got=%h want=%h", din_seen, exp_din); end
        total++; if (acc_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=%0d", acc_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL b2b_access%0d got=%h want=%h", i, acc_q[i], exp_q[i]); end
        end
        idle_bus(1);
    endtask

    task automatic test_random();
        logic        rd;
        logic [3:0]  wr;
        logic [23:0] a;
        logic [31:0] d;
        int          kind;
        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 2));
            rd   = (kind != 1);
            wr   = (kind == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            a    = {4'($urandom), 8'h00, 12'($urandom)};
            d    = $urandom;
            model_req(rd, wr, a, d);
            cpu_access(rd, wr, a, d);
            total++; if (timed_out || stall !== exp_stall) begin bad++; $display("[TB] FAIL rand%0d_stall got=%0d want=%0d", t, stall, exp_stall); end
            total++; if (din_seen !== exp_din) begin bad++; $display("[TB] FAIL rand%0d_din got=%h want=%h", t, din_seen, exp_din); end
            total++; if (acc_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL rand%0d_count got=%0d want=%0d", t, acc_q.size(), exp_q.size()); end
            else for (int i = 0; i < exp_q.size(); i++) begin
                total++; if (acc_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL rand%0d_access%0d got=%h want=%h", t, i, acc_q[i], exp_q[i]); end
            end
            if ($urandom_range(0, 1) == 1) idle_bus(1);
        end
        idle_bus(1);
    endtask

    task automatic test_reset_mid();
        int   starts = 0;
        logic prev = 1'b1;
        @(negedge i_clk);
        i_ram_rd = 1'b1;
        i_daddr  = 24'h000104;
        for (int c = 0; c < 100 && starts < 3; c++) begin
            @(negedge i_clk);
            if (!o_sram_oeb && prev) starts++;
            prev = o_sram_oeb;
        end
        total++; if (starts !== 3) begin bad++; $display("[TB] FAIL midrst_third_strobe got=%0d want=3", starts); end
        #2 i_rstb = 1'b0;
        #1;
        total++; if ({o_sram_ceb, o_sram_oeb, o_sram_web} !== 3'b111) begin bad++; $display("[TB] FAIL midrst_strobes got=%b want=111", {o_sram_ceb, o_sram_oeb, o_sram_web}); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", o_busy); end
        i_ram_rd = 1'b0;
        i_daddr  = 24'd0;
        @(negedge i_clk);
        i_rstb = 1'b1;
        exp_din = 32'h0;
        repeat (2) @(negedge i_clk);
        total++; if (o_cpu_clk_en !== 1'b1) begin bad++; $display("[TB] FAIL midrst_clk_en got=%b want=1", o_cpu_clk_en); end
        total++; if (o_din !== exp_din) begin bad++; $display("[TB] FAIL midrst_din got=%h want=%h", o_din, exp_din); end
        model_req(1'b1, 4'd0, 24'h000104, 32'd0);
        cpu_access(1'b1, 4'd0, 24'h000104, 32'd0);
        total++; if (din_seen !== exp_din) begin bad++; $display("[TB] FAIL midrst_reread got=%h want=%h", din_seen, exp_din); end
        idle_bus(1);
    endtask

    initial begin
        i_rstb   = 1'b1;
        i_ram_rd = 1'b0;
        i_ram_wr = 4'd0;
        i_daddr  = 24'd0;
        i_dout   = 32'd0;
        exp_din  = 32'h0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
        ref_mem[12'h104] = 8'h11;
        ref_mem[12'h105] = 8'h22;
        ref_mem[12'h106] = 8'h33;
        ref_mem[12'h107] = 8'h44;
        #2;
        test_reset();
        test_read();
        test_write();
        test_priority();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/sram_bridge_2432.md
Name: sram_bridge_2432

Overview:
Memory-side responder for the 2432 CPU data port. It accepts the CPU's single-cycle byte-enabled read/write requests and converts each one into a sequence of byte-wide accesses to an external asynchronous 8-bit SRAM. While an access is in flight it stalls the CPU through the CPU clock-enable. It sits between the CPU data bus (daddr/dout/ram_rd/ram_wr/din/clk_en) and the board SRAM pins. The instruction port is not handled here.

Parameters:
ADDR_W, 20, external SRAM byte-address width (legal range 3..24).
WAIT_STATES, 1, extra strobe cycles per byte access (legal range 0..7).

Ports:
i_clk  input  1  system clock.
i_rstb  input  1  reset, asynchronous, active-low.
i_daddr  input  24  CPU byte address (combinational from CPU; stable while o_cpu_clk_en=0).
i_dout  input  32  CPU write data, already lane-shifted.
i_ram_rd  input  1  CPU read request (whole aligned word).
i_ram_wr  input  4  CPU write byte-enables; lane k = bits 8k+7:8k.
o_din  output  32  read data returned to CPU.
o_cpu_clk_en  output  1  CPU clock enable; 0 = stall.
o_sram_addr  output  ADDR_W  SRAM byte address.
o_sram_dout  output  8  SRAM write data.
i_sram_din  input  8  SRAM read data.
o_sram_ceb  output  1  SRAM chip enable, active-low.
o_sram_oeb  output  1  SRAM output enable, active-low.
o_sram_web  output  1  SRAM write enable, active-low.
o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values, applied asynchronously: state=IDLE; o_sram_ceb=o_sram_oeb=o_sram_web=1; o_sram_addr=0; o_sram_dout=0; o_din=0; o_busy=0.
- o_cpu_clk_en is combinational: 1 when (IDLE and no request) or in DONE; 0 otherwise.
- Request definition: i_ram_rd=1 or i_ram_wr!=0. Requests are sampled only in IDLE.
- States: IDLE, SETUP, STROBE, DONE.
- IDLE: on a request, latch the request type, the 4-bit lane mask (reads: 4'b1111; writes: i_ram_wr), word address i_daddr[ADDR_W-1:2] and i_dout. Select the lowest set lane. Go to SETUP. o_cpu_clk_en=0 in this cycle.
- Write priority: if read and write are asserted together, perform the write. The read is dropped.
- SETUP (1 cycle): o_sram_addr={word_addr, lane[1:0]}; o_sram_dout=write-data lane byte; ceb=0; oeb=web=1. Go to STROBE.
- STROBE (WAIT_STATES+1 cycles, counted by a wait counter): ceb=0; oeb=0 for reads, web=0 for writes.
  - Reads: on the clock edge that ends the final STROBE cycle, capture i_sram_din into shadow lane byte.
  - On exit, clear the finished lane from the mask. If lanes remain, go to SETUP with the next lowest lane (strobes high for that SETUP). Otherwise go to DONE.
- DONE (1 cycle): ceb=oeb=web=1; o_cpu_clk_en=1.
  - Reads: o_din is loaded with the full shadow word on entry to DONE. It holds until the next read completes; writes never change o_din.
  - The still-present request is ignored. Return to IDLE.
- Write lanes with enable 0 are skipped entirely (no SETUP/STROBE for them). Lane order is ascending.
- Stall length: reads = 1 + 4*(WAIT_STATES+2) cycles. Writes = 1 + n*(WAIT_STATES+2), where n = number of enabled lanes.
- Address bits above ADDR_W-1 are ignored, so the SRAM address wraps.
- Reset mid-operation: strobes go inactive immediately; the partial access is abandoned and the shadow register is cleared.

Decomposition:
- Add a shared header mem_2432.vh (beside cpu_2432.vh) holding the state encodings, the lane width (8) and the lane count (4).
- One natural sub-module: sram_byte_cycle. It sequences a single SETUP/STROBE byte access (wait counter, strobes, read capture) and reports done. The parent handles lane selection, request latching and the clk_en/DONE handshake.

Test Plan:
All timings below use WAIT_STATES=1.
- Read at i_daddr=0x000104, SRAM bytes [0x104..0x107]=11,22,33,44 -> o_cpu_clk_en low for exactly 13 cycles, then high 1 cycle; o_din=0x44332211; oeb pulses 2 cycles per byte at addresses 0x104..0x107 ascending.
- Write i_ram_wr=4'b0100, i_dout=0x00AB0000, i_daddr=0x000202 -> one web pulse of 2 cycles at o_sram_addr=0x202 with data 0xAB; clk_en low 4 cycles; o_din unchanged.
- Write i_ram_wr=4'b1010, i_dout=0xDD00BB00 at 0x300 -> web pulses at 0x301 (0xBB) then 0x303 (0xDD); lanes 0 and 2 untouched; clk_en low 7 cycles.
- Back-to-back: read then write presented in consecutive CPU cycles -> DONE, IDLE, then the second request starts with no lost or duplicated access; o_din keeps the read word.
- i_ram_rd=1 and i_ram_wr=4'b1111 together -> write performed, no oeb activity.
- Assert i_rstb=0 during the third STROBE of a read -> ceb/oeb/web=1 and o_busy=0 immediately; after release, IDLE with o_cpu_clk_en=1 when no request.
